// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot state indices, frame constants and small helpers.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int unsigned IDLE          = 0;
    localparam int unsigned START         = 1;
    localparam int unsigned DATA          = 2;
    localparam int unsigned STOP          = 3;
    localparam int unsigned NUM_STATES    = 4;

    localparam int unsigned DATA_BITS     = 8;
    localparam int unsigned MIN_CLK_RATIO = 3;

    typedef logic [NUM_STATES-1:0] state_t;

    function automatic state_t onehot(input int unsigned idx);
        state_t s;
        s      = '0;
        s[idx] = 1'b1;
        return s;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input synchronizer for the UART receive line plus falling-edge detector.
// SYNC_STAGES selects 2 or 3 flops; all flops reset to the idle (high) level.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '1;
            rx_s_prev_q <= 1'b1;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_s_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    // A held-low line (break) never re-arms until rx_s has been high again.
    assign fall = rx_s_prev_q & ~rx_s;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with one-hot FSM; bit period is clk_ratio+1 clocks, latched per frame.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each sample point.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic [7:0] clk_ratio,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       rx_active
);

    localparam int unsigned IdxW = $clog2(DATA_BITS);

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [7:0]           ratio_q, ratio_d;
    logic [7:0]           start_tgt;
    logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 dv_q, dv_d;
    logic                 fe_q, fe_d;
    logic                 rx_s, fall, hit, sample;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .rx_s  (rx_s),
        .fall  (fall)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    // Decide one cycle late using the last three rx_s values; the count restarts
    // at each decision, so bit targets stay at ratio_q and the period is unchanged.
    assign start_tgt = (ratio_q >> 1) + 8'd1;
    assign sample    = maj3(rx_s, hist_q[0], hist_q[1]);
`else
    assign start_tgt = ratio_q >> 1;
    assign sample    = rx_s;
`endif

    assign hit = state_q[START] ? (cnt_q == start_tgt) : (cnt_q == ratio_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= onehot(IDLE);
            cnt_q     <= 8'd0;
            ratio_q   <= 8'd0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            dv_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ratio_q   <= ratio_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            fe_q      <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            state_q[IDLE]:  if (fall) state_d = onehot(START);
            state_q[START]: if (hit) state_d = sample ? onehot(IDLE) : onehot(DATA);
            state_q[DATA]: begin
                if (hit && bit_idx_q == IdxW'(DATA_BITS - 1)) state_d = onehot(STOP);
            end
            state_q[STOP]:  if (hit) state_d = onehot(IDLE);
            default:        state_d = onehot(IDLE);
        endcase
    end

    always_comb begin
        cnt_d     = state_q[IDLE] ? 8'd0 : cnt_q + 8'd1;
        ratio_d   = ratio_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        fe_d      = 1'b0;
        unique case (1'b1)
            state_q[IDLE]: begin
                if (fall) ratio_d = clk_ratio;
            end
            state_q[START]: begin
                if (hit) begin
                    cnt_d     = 8'd0;
                    bit_idx_d = '0;
                end
            end
            state_q[DATA]: begin
                if (hit) begin
                    cnt_d              = 8'd0;
                    shift_d[bit_idx_q] = sample;
                    bit_idx_d          = bit_idx_q + 1'b1;
                end
            end
            state_q[STOP]: begin
                if (hit) begin
                    cnt_d = 8'd0;
                    if (sample) begin
                        data_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        fe_d   = 1'b1;
                    end
                end
            end
            default: cnt_d = 8'd0;
        endcase
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign frame_err  = fe_q;
    assign rx_active  = ~state_q[IDLE];

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: table of framed bytes plus hand-written corner sequences.
// Honours UART_RX_MAJORITY_EN (one extra cycle of latency, glitch-tolerance sequence).
module tb_uart_rx_core;

`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] clk_ratio;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       rx_active;

    uart_rx_core #(
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .clk_ratio  (clk_ratio),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .rx_active  (rx_active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor on the falling edge, away from the active edge.
    int         cyc = 0;
    int         dv_cnt = 0, fe_cnt = 0, both_cnt = 0;
    int         act_cycles = 0, act_rise_cnt = 0, act_rise_cyc = 0, dv_cyc = 0;
    logic       act_prev = 1'b0;
    logic [7:0] dv_log[$];

    always @(negedge clk) begin
        cyc++;
        if (data_valid) begin
            dv_cnt++;
            dv_cyc = cyc;
            dv_log.push_back(data);
        end
        if (frame_err) fe_cnt++;
        if (data_valid && frame_err) both_cnt++;
        if (rx_active) act_cycles++;
        if (rx_active && !act_prev) begin
            act_rise_cnt++;
            act_rise_cyc = cyc;
        end
        act_prev = rx_active;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int per,
                              input bit glitch);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (glitch) begin
                rx = bits[i];
                tick(per / 2);
                rx = ~bits[i];
                tick(1);
                rx = bits[i];
                tick(per - per / 2 - 1);
            end else begin
                rx = bits[i];
                tick(per);
            end
        end
    endtask

    typedef struct {
        logic [7:0] ratio;
        logic [7:0] tx_byte;
        logic       stop_bit;
        logic [7:0] exp_data;
        int         exp_dv;
        int         exp_fe;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int dv0, fe0, act0, rise0;

        vecs[0] = '{8'd15,  8'hA5, 1'b1, 8'hA5, 1, 0};
        vecs[1] = '{8'd3,   8'h00, 1'b1, 8'h00, 1, 0};
        vecs[2] = '{8'd7,   8'hFF, 1'b1, 8'hFF, 1, 0};
        vecs[3] = '{8'd15,  8'h55, 1'b0, 8'hFF, 0, 1};
        vecs[4] = '{8'd4,   8'h81, 1'b1, 8'h81, 1, 0};
        vecs[5] = '{8'd255, 8'h3C, 1'b1, 8'h3C, 1, 0};

        rx        = 1'b1;
        clk_ratio = 8'd15;
        rst_n     = 1'b0;
        tick(3);
        check("reset_data",       int'(data),       0);
        check("reset_data_valid", int'(data_valid), 0);
        check("reset_frame_err",  int'(frame_err),  0);
        check("reset_rx_active",  int'(rx_active),  0);
        rst_n = 1'b1;
        tick(5);

        // Single 0xA5 frame: latency from START entry to data_valid.
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_frame(8'hA5, 1'b1, 16, 1'b0);
        tick(40);
        check("a5_dv_count",  dv_cnt - dv0, 1);
        check("a5_fe_count",  fe_cnt - fe0, 0);
        check("a5_data",      int'(data), 8'hA5);
        check("a5_latency",   dv_cyc - act_rise_cyc, 152 + MAJ);

        foreach (vecs[i]) begin
            clk_ratio = vecs[i].ratio;
            dv0 = dv_cnt; fe0 = fe_cnt;
            send_frame(vecs[i].tx_byte, vecs[i].stop_bit, int'(vecs[i].ratio) + 1, 1'b0);
            rx = 1'b1;
            tick(2 * (int'(vecs[i].ratio) + 1) + 8);
            check($sformatf("vec%0d_dv", i),   dv_cnt - dv0, vecs[i].exp_dv);
            check($sformatf("vec%0d_fe", i),   fe_cnt - fe0, vecs[i].exp_fe);
            check($sformatf("vec%0d_data", i), int'(data),   int'(vecs[i].exp_data));
        end

        // Back-to-back frames with no idle gap.
        clk_ratio = 8'd15;
        dv_log.delete();
        send_frame(8'h3C, 1'b1, 16, 1'b0);
        send_frame(8'hC3, 1'b1, 16, 1'b0);
        rx = 1'b1;
        tick(40);
        check("b2b_count", dv_log.size(), 2);
        if (dv_log.size() == 2) begin
            check("b2b_first",  int'(dv_log[0]), 8'h3C);
            check("b2b_second", int'(dv_log[1]), 8'hC3);
        end

        // Framing error followed by a held-low break line.
        dv0 = dv_cnt; fe0 = fe_cnt; rise0 = act_rise_cnt;
        send_frame(8'h55, 1'b0, 16, 1'b0);
        tick(100);
        check("brk_fe",        fe_cnt - fe0, 1);
        check("brk_dv",        dv_cnt - dv0, 0);
        check("brk_data_kept", int'(data), 8'hC3);
        check("brk_no_retrig", act_rise_cnt - rise0, 1);
        check("brk_idle",      int'(rx_active), 0);
        rx = 1'b1;
        tick(20);
        send_frame(8'h6E, 1'b1, 16, 1'b0);
        tick(40);
        check("brk_recover", int'(data), 8'h6E);

        // Four-cycle low glitch: false start, no pulse.
        dv0 = dv_cnt; fe0 = fe_cnt; act0 = act_cycles;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        check("glitch_act_cycles", act_cycles - act0, 8 + MAJ);
        check("glitch_no_pulse",   (dv_cnt - dv0) + (fe_cnt - fe0), 0);

        // clk_ratio changed mid-frame must not disturb the frame in flight.
        dv0 = dv_cnt;
        fork
            send_frame(8'h4B, 1'b1, 16, 1'b0);
            begin
                tick(40);
                clk_ratio = 8'd200;
            end
        join
        tick(40);
        check("ratio_change_dv",   dv_cnt - dv0, 1);
        check("ratio_change_data", int'(data), 8'h4B);

        // Reset during bit 4 of 0xFF at clk_ratio=31.
        clk_ratio = 8'd31;
        dv0 = dv_cnt; fe0 = fe_cnt;
        rx = 1'b0;
        tick(32);
        rx = 1'b1;
        tick(32 * 4 + 16);
        rst_n = 1'b0;
        tick(1);
        check("midrst_data",      int'(data),       0);
        check("midrst_valid",     int'(data_valid), 0);
        check("midrst_frame_err", int'(frame_err),  0);
        check("midrst_active",    int'(rx_active),  0);
        tick(3);
        rst_n = 1'b1;
        tick(32 * 6);
        check("midrst_no_pulse", (dv_cnt - dv0) + (fe_cnt - fe0), 0);
        send_frame(8'h81, 1'b1, 32, 1'b0);
        tick(80);
        check("midrst_next_dv",   dv_cnt - dv0, 1);
        check("midrst_next_data", int'(data), 8'h81);

`ifdef UART_RX_MAJORITY_EN
        // One-cycle inverted glitch at the centre of every bit.
        clk_ratio = 8'd15;
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_frame(8'h96, 1'b1, 16, 1'b1);
        rx = 1'b1;
        tick(40);
        check("maj_glitch_dv",   dv_cnt - dv0, 1);
        check("maj_glitch_fe",   fe_cnt - fe0, 0);
        check("maj_glitch_data", int'(data), 8'h96);
`endif

        check("no_overlap", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
